// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - hz_state_e : hazard sequencer states (also the Hazard_State debug encoding)
//   - REG_ZERO   : the hard-wired zero register, never a hazard source
//   - opcode/funct constants plus decode_flags(), which derives the Decode_*
//     flags the hazard controller consumes from a raw instruction
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_MD_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    typedef struct packed {
        logic uses_rt;
        logic is_branch;
        logic is_muldiv;
        logic reads_hilo;
    } decode_flags_t;

    function automatic decode_flags_t decode_flags(input logic [5:0] op, input logic [5:0] funct);
        decode_flags_t f;
        logic rtype;
        rtype        = (op == OP_RTYPE);
        f.reads_hilo = rtype && (funct == FN_MFHI || funct == FN_MFLO);
        f.is_muldiv  = rtype && (funct == FN_MULT || funct == FN_MULTU ||
                                 funct == FN_DIV  || funct == FN_DIVU);
        f.is_branch  = (op == OP_BEQ) || (op == OP_BNE) || (rtype && funct == FN_JR);
        // jr and mfhi/mflo do not read Rt; every other R-type does, as do beq/bne/sw
        f.uses_rt    = (rtype && !(funct == FN_JR) && !f.reads_hilo) ||
                       (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        return f;
    endfunction

endpackage

// File: rtl/hilo_busy_counter.sv
// HI/LO busy tracker: a 4-bit down-counter that marks the multiply/divide
// unit busy after a mult/div issues.
//   Clk, Rst_n : clock, async active-low reset
//   issue      : a mult/div leaves ID unstalled this cycle
//   busy       : HI/LO result not yet readable (count != 0)
module hilo_busy_counter #(
    parameter int MULDIV_LAT = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic issue,
    output logic busy
);

    // The issue cycle itself is the first of the MULDIV_LAT busy cycles, so
    // the counter covers the remaining MULDIV_LAT-1. A back-to-back mfhi/mflo
    // therefore waits MULDIV_LAT-1 cycles, and the 2..15 range keeps the load
    // value nonzero and inside 4 bits.
    localparam logic [3:0] LOAD_VAL = 4'(MULDIV_LAT - 1);

    logic [3:0] md_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            md_cnt <= '0;
        end else if (issue) begin
            md_cnt <= LOAD_VAL;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign busy = (md_cnt != 4'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard/stall sequencer for the 5-stage MIPS pipeline.
// Catches what forwarding cannot: load-use, branch operands not ready in ID,
// and HI/LO reads or new mult/div while the multiplier is still busy.
//   Inputs : IDEX_* / EXMEM_* producer info, Decode_* consumer info,
//            Branch_Taken from the ID branch comparator
//   Outputs: PCWrite, IFID_Write (0 = hold), IFID_Flush (taken branch),
//            IDEX_Bubble (insert NOP), Hazard_State (debug)
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int REG_W      = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] IDEX_RegDst,
    input  logic             EXMEM_MemRead,
    input  logic [REG_W-1:0] EXMEM_RegDst,
    input  logic [REG_W-1:0] Decode_RegisterRs,
    input  logic [REG_W-1:0] Decode_RegisterRt,
    input  logic             Decode_UsesRt,
    input  logic             Decode_IsBranch,
    input  logic             Branch_Taken,
    input  logic             Decode_IsMulDiv,
    input  logic             Decode_ReadsHiLo,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic [1:0]       Hazard_State
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

    hz_state_e  state;
    logic [1:0] stall_cnt;
    logic       md_busy;
    logic       stall;

    // Source-operand matches against the EX and MEM destinations.
    logic hit_ex, hit_mem;
    assign hit_ex  = (IDEX_RegDst != ZERO) &&
                     ((IDEX_RegDst == Decode_RegisterRs) ||
                      (Decode_UsesRt && IDEX_RegDst == Decode_RegisterRt));
    assign hit_mem = (EXMEM_RegDst != ZERO) &&
                     ((EXMEM_RegDst == Decode_RegisterRs) ||
                      (Decode_UsesRt && EXMEM_RegDst == Decode_RegisterRt));

    logic h_lu, h_br1, h_br2, h_brm, h_md, h_one;
    assign h_lu  = IDEX_MemRead && hit_ex;
    assign h_br1 = Decode_IsBranch && IDEX_RegWrite && !IDEX_MemRead && hit_ex;
    assign h_br2 = Decode_IsBranch && IDEX_MemRead && hit_ex;
    assign h_brm = Decode_IsBranch && EXMEM_MemRead && hit_mem;
    assign h_md  = (Decode_ReadsHiLo || Decode_IsMulDiv) && md_busy;
    // Single-cycle hazards: the producer advances one stage and the hazard clears.
    assign h_one = h_lu || h_br1 || h_brm;

    // Mealy stall; forced low while in reset so outputs snap to their idle values.
    always_comb begin
        stall = 1'b0;
        if (Rst_n) begin
            case (state)
                ST_RUN:     stall = h_br2 || h_one || h_md;
                ST_STALL:   stall = 1'b1;
                ST_MD_WAIT: stall = md_busy;
                default:    stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (h_br2) begin
                        // One stall now plus one more in STALL lets the load
                        // reach WB-forwarding range of the branch comparator.
                        state     <= ST_STALL;
                        stall_cnt <= 2'd1;
                    end else if (!h_one && h_md) begin
                        state <= ST_MD_WAIT;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt <= 2'd1) begin
                        state     <= ST_RUN;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt - 2'd1;
                    end
                end
                ST_MD_WAIT: begin
                    if (!md_busy) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Reload only when the mult/div actually moves to EX; a stalled one
    // (including one held by H_MD) leaves the running count alone.
    hilo_busy_counter #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_hilo_busy (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .issue (Decode_IsMulDiv && !stall),
        .busy  (md_busy)
    );

    assign PCWrite      = !stall;
    assign IFID_Write   = !stall;
    assign IDEX_Bubble  = stall;
    // A taken branch seen during a stall is dropped; it resolves again on release.
    assign IFID_Flush   = Rst_n && Branch_Taken && !stall;
    assign Hazard_State = state;

endmodule
